spi_master: RTL and testbench

- SPI initiator for the CPLD board-control slave: it addresses the switch/LED, user-pin or flash targets.
- Clocked from the system clock. It generates SPICLK, SPIMOSI, SPICS_N and SPIADDR from a START/WDATA request.
- Each transaction writes one byte to the target and captures one byte from SPIMISO.
- Sits between host-side control logic and the board SPI bus.

---
 rtl/spi_master.sv | 186 ++++++++++++++++++
 tb/tb_spi_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_master                                                   |
// | Description : SPI initiator for the CPLD board-control slave; writes one   |
// |               byte and captures one byte per transaction.                  |
// | Option      : SPI_MISO_CHECK_EN enables the MISO_ENA fault flag on ERR.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_master #(
  parameter int HALF = 4,
  parameter int NCLK = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] ADDR,
  input  logic [7:0] WDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RDATA,
  output logic       ERR,
  output logic       SPICLK,
  output logic       SPIMOSI,
  output logic       SPICS_N,
  output logic [1:0] SPIADDR,
  input  logic       SPIMISO,
  input  logic       MISO_ENA
);

  localparam int            CW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] c_half_m1 = CW'(HALF - 1);
  localparam logic [3:0]    c_last_bit = 4'(NCLK - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    bit_q;
  logic [7:0]    wsh_q;
  logic [15:0]   cap_q;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    rdata_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          cs_n_q;
  logic [1:0]    addr_q;
  logic          cnt_zero;

  assign cnt_d    = cnt_q - CW'(1);
  assign cnt_zero = (cnt_q == '0);

`ifdef SPI_MISO_CHECK_EN
  logic err_q;
  logic bad_q;
  logic unused_bits;
  assign ERR         = err_q;
  assign unused_bits = cap_q[15];
`else
  logic unused_bits;
  assign ERR         = 1'b0;
  assign unused_bits = ^{cap_q[15], MISO_ENA};
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      wsh_q   <= '0;
      cap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      addr_q  <= 2'b11;
`ifdef SPI_MISO_CHECK_EN
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            wsh_q   <= WDATA;
            addr_q  <= ADDR;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cap_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= c_half_m1;
            state_q <= S_SETUP;
`ifdef SPI_MISO_CHECK_EN
            bad_q   <= 1'b0;
`endif
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            mosi_q  <= wsh_q[7];
            wsh_q   <= {wsh_q[6:0], 1'b0};
            cnt_q   <= c_half_m1;
            state_q <= S_LOW;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_LOW: begin
          if (cnt_zero) begin
            sclk_q  <= 1'b1;
            cap_q   <= {cap_q[14:0], SPIMISO};
            cnt_q   <= c_half_m1;
            state_q <= S_HIGH;
`ifdef SPI_MISO_CHECK_EN
            bad_q   <= bad_q | ~MISO_ENA;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_HIGH: begin
          if (cnt_zero) begin
            sclk_q <= 1'b0;
            cnt_q  <= c_half_m1;
            if (bit_q == c_last_bit) begin
              mosi_q  <= 1'b0;
              state_q <= S_HOLD;
            end else begin
              // The write byte empties after 8 shifts, so trailing bits drive 0.
              mosi_q  <= wsh_q[7];
              wsh_q   <= {wsh_q[6:0], 1'b0};
              bit_q   <= bit_q + 4'd1;
              state_q <= S_LOW;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            rdata_q <= cap_q[7:0];
            cnt_q   <= c_half_m1;
            state_q <= S_GAP;
`ifdef SPI_MISO_CHECK_EN
            err_q   <= bad_q;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_GAP: begin
          if (cnt_zero) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign RDATA   = rdata_q;
  assign SPICLK  = sclk_q;
  assign SPIMOSI = mosi_q;
  assign SPICS_N = cs_n_q;
  assign SPIADDR = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// Randomised bench for spi_master: a transaction-level timing model predicts every
// output each cycle, and a small register slave checks the bus-level byte alignment.
module tb_spi_master;
  localparam int HALF   = 4;
  localparam int NCLK   = 10;
  localparam int T_PH   = HALF;
  localparam int T_HOLD = HALF + 2 * HALF * NCLK;
  localparam int T_DONE = T_HOLD + HALF;
  localparam int T_IDLE = T_DONE + HALF;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [1:0] ADDR = 2'b00;
  logic [7:0] WDATA = 8'h00;
  logic       MISO_ENA = 1'b1;
  wire        SPIMISO;
  logic       BUSY, DONE, ERR, SPICLK, SPIMOSI, SPICS_N;
  logic [7:0] RDATA;
  logic [1:0] SPIADDR;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  spi_master #(.HALF(HALF), .NCLK(NCLK)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ADDR(ADDR), .WDATA(WDATA),
    .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .ERR(ERR), .SPICLK(SPICLK),
    .SPIMOSI(SPIMOSI), .SPICS_N(SPICS_N), .SPIADDR(SPIADDR),
    .SPIMISO(SPIMISO), .MISO_ENA(MISO_ENA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Register slave: MISO changes after each SPICLK fall, MOSI shifts in on the rise.
  logic [15:0] miso_bits = 16'h0000;
  logic [4:0]  fall_cnt = 5'd0;
  logic [7:0]  sl_sh = 8'h00;
  logic [7:0]  led_q = 8'h00;
  int          rise_cnt = 0;

  assign SPIMISO = miso_bits[fall_cnt[3:0]];

  always @(posedge SPICLK) begin
    sl_sh    = {sl_sh[6:0], SPIMOSI};
    rise_cnt = rise_cnt + 1;
  end

  always @(negedge SPICLK or posedge SPICS_N) begin
    if (SPICS_N === 1'b1) fall_cnt = 5'd0;
    else begin
      fall_cnt = fall_cnt + 5'd1;
      if (fall_cnt == 5'd8 && SPIADDR == 2'b01) led_q = sl_sh;
    end
  end

  // Transaction-level model: position within a transaction is just a cycle offset.
  bit         m_act = 1'b0;
  int         m_t = 0;
  logic [7:0] m_wd = 8'h00;
  logic [1:0] m_addr = 2'b11;
  logic [7:0] m_rdata = 8'h00;
  logic       m_err = 1'b0;
  bit         m_bad = 1'b0;
  bit         m_samp[$];

  always @(posedge CLK) begin
    if (RESET) begin
      m_act = 1'b0; m_t = 0; m_addr = 2'b11; m_rdata = 8'h00; m_err = 1'b0;
    end else if (m_act) begin
      m_t = m_t + 1;
      if (m_t >= T_PH && m_t < T_HOLD && ((m_t - T_PH) % (2 * HALF)) == HALF) begin
        m_samp.push_back(SPIMISO);
        if (!MISO_ENA) m_bad = 1'b1;
      end
      if (m_t == T_DONE) begin
        for (int k = 0; k < 8; k++) m_rdata[7-k] = m_samp[NCLK-8+k];
`ifdef SPI_MISO_CHECK_EN
        m_err = m_bad;
`endif
      end
      if (m_t == T_IDLE) m_act = 1'b0;
    end else if (START) begin
      m_act = 1'b1; m_t = 0; m_wd = WDATA; m_addr = ADDR; m_bad = 1'b0;
      m_samp.delete();
    end
  end

  function automatic logic exp_sclk();
    return m_act && m_t >= T_PH && m_t < T_HOLD && (((m_t - T_PH) / HALF) % 2 == 1);
  endfunction

  function automatic logic exp_mosi();
    int b;
    if (!(m_act && m_t >= T_PH && m_t < T_HOLD)) return 1'b0;
    b = (m_t - T_PH) / (2 * HALF);
    return (b < 8) ? m_wd[7-b] : 1'b0;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      check("BUSY", 16'(BUSY), 16'(m_act));
      check("SPICS_N", 16'(SPICS_N), 16'(!(m_act && m_t < T_DONE)));
      check("SPICLK", 16'(SPICLK), 16'(exp_sclk()));
      check("SPIMOSI", 16'(SPIMOSI), 16'(exp_mosi()));
      check("DONE", 16'(DONE), 16'(m_act && m_t == T_DONE));
      check("RDATA", 16'(RDATA), 16'(m_rdata));
      check("ERR", 16'(ERR), 16'(m_err));
      check("SPIADDR", 16'(SPIADDR), 16'(m_addr));
    end
  end

  task automatic set_rd(input logic [7:0] rd);
    miso_bits = 16'($urandom);
    for (int k = 0; k < 8; k++) miso_bits[2+k] = rd[7-k];
  endtask

  // One transaction; cycle c counts negedges after the START-sampling edge region.
  task automatic txn(input logic [1:0] a, input logic [7:0] wd, input int reject_at,
                     input int reset_at, output int done_at, output int idle_at,
                     output int ndone, output logic [7:0] rd_at_done);
    @(negedge CLK);
    ADDR = a; WDATA = wd; START = 1'b1;
    done_at = -1; idle_at = -1; ndone = 0; rd_at_done = 8'h00;
    for (int c = 1; c <= 150; c++) begin
      @(negedge CLK);
      if (DONE) begin
        ndone++;
        if (done_at < 0) begin done_at = c; rd_at_done = RDATA; end
      end
      if (!BUSY && idle_at < 0) idle_at = c;
      if (c == reset_at + 1) begin
        check("rst_mid_cs_n", 16'(SPICS_N), 16'd1);
        check("rst_mid_sclk", 16'(SPICLK), 16'd0);
        check("rst_mid_busy", 16'(BUSY), 16'd0);
        check("rst_mid_rdata", 16'(RDATA), 16'h00);
      end
      START = (c == reject_at);
      if (c == reject_at) WDATA = 8'hFF;
      RESET = (c == reset_at);
    end
  endtask

  int         d_at, i_at, nd, rb, bfall, cfall;
  logic [7:0] rd;
  bit         seen_busy;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 expected completion");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_cs_n", 16'(SPICS_N), 16'd1);
    check("reset_sclk", 16'(SPICLK), 16'd0);
    check("reset_addr", 16'(SPIADDR), 16'h3);
    check("reset_busy", 16'(BUSY), 16'd0);
    check("reset_done", 16'(DONE), 16'd0);
    check("reset_rdata", 16'(RDATA), 16'h00);
    check("reset_err", 16'(ERR), 16'd0);
    RESET = 1'b0;
    MISO_ENA = 1'b1;

    // Write A5 / read 3C, with a rejected START at cycle 20.
    set_rd(8'h3C);
    rb = rise_cnt;
    txn(2'b01, 8'hA5, 20, -1, d_at, i_at, nd, rd);
    check("write_done_cycle", 16'(d_at), 16'd89);
    check("write_idle_cycle", 16'(i_at), 16'd93);
    check("write_one_done", 16'(nd), 16'd1);
    check("write_rises", 16'(rise_cnt - rb), 16'd10);
    check("write_led", 16'(led_q), 16'hA5);
    check("read_button", 16'(rd), 16'h3C);

    // User-pin target.
    set_rd(8'hC3);
    txn(2'b10, 8'h5E, -1, -1, d_at, i_at, nd, rd);
    check("read_user", 16'(rd), 16'hC3);
    check("user_done_cycle", 16'(d_at), 16'd89);

    // START held high: the next CS fall follows BUSY falling by one cycle.
    @(negedge CLK);
    ADDR = 2'b01; WDATA = 8'h5A; START = 1'b1;
    seen_busy = 1'b0; bfall = -1; cfall = -1;
    for (int c = 1; c <= 300 && cfall < 0; c++) begin
      @(negedge CLK);
      if (BUSY) seen_busy = 1'b1;
      if (seen_busy && !BUSY && bfall < 0) bfall = c;
      else if (bfall >= 0 && !SPICS_N) cfall = c;
    end
    START = 1'b0;
    check("held_cs_after_busy", 16'(cfall - bfall), 16'd1);
    for (int c = 0; c < 200 && BUSY; c++) @(negedge CLK);
    check("held_led", 16'(led_q), 16'h5A);

    // Reset at cycle 40: no DONE, LED untouched.
    txn(2'b01, 8'h33, -1, 40, d_at, i_at, nd, rd);
    check("rst_no_done", 16'(nd), 16'd0);
    check("rst_led_kept", 16'(led_q), 16'h5A);

    // MISO_ENA fault flag.
    MISO_ENA = 1'b0;
    txn(2'b00, 8'h81, -1, -1, d_at, i_at, nd, rd);
`ifdef SPI_MISO_CHECK_EN
    check("err_set", 16'(ERR), 16'd1);
`else
    check("err_off", 16'(ERR), 16'd0);
`endif
    MISO_ENA = 1'b1;
    txn(2'b00, 8'h18, -1, -1, d_at, i_at, nd, rd);
    check("err_clear", 16'(ERR), 16'd0);

    // Random traffic including START bursts during BUSY and occasional resets.
    for (int c = 0; c < 5000; c++) begin
      @(negedge CLK);
      START    = ($urandom_range(0, 7) == 0);
      ADDR     = 2'($urandom);
      WDATA    = 8'($urandom);
      MISO_ENA = ($urandom_range(0, 15) != 0);
      RESET    = ($urandom_range(0, 1499) == 0);
      if (DONE || !BUSY) miso_bits = 16'($urandom);
    end
    START = 1'b0; RESET = 1'b0;
    repeat (120) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
